// File: rtl/bus_src_arbiter_if.sv
// Common-bus source selector handshake: per-source requests in, select/grant out.
interface bus_src_arbiter_if #(
    parameter int unsigned N_SRC = 7,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned CNT_W = 8
);
    logic [N_SRC-1:0] req;
    logic             rr_mode;
    logic             hold;
    logic             clr_cnt;
    logic [SEL_W-1:0] sel;
    logic [N_SRC-1:0] grant;
    logic             bus_valid;
    logic             conflict;
    logic [CNT_W-1:0] conflict_cnt;

    // Requester side: drives requests and controls, observes the selection.
    modport master (
        output req, rr_mode, hold, clr_cnt,
        input  sel, grant, bus_valid, conflict, conflict_cnt
    );

    // Arbiter side.
    modport slave (
        input  req, rr_mode, hold, clr_cnt,
        output sel, grant, bus_valid, conflict, conflict_cnt
    );
endinterface

// File: rtl/bus_src_arbiter.sv
// Registered common-bus source selector: fixed-priority or round-robin
// arbitration with ownership hold and a saturating request-conflict counter.
module bus_src_arbiter #(
    parameter int unsigned N_SRC = 7,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_src_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   fix_win, rr_win;
    logic               any_req, conflict_now, arb;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic               valid_q, valid_d;
    logic               conflict_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    int                 idx;

    assign any_req      = |bus.req;
    assign conflict_now = ($countones(bus.req) >= 2);

    // Candidate winners: lowest set index, and first set index after the pointer.
    always_comb begin
        fix_win = '0;
        rr_win  = '0;
        idx     = 0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (bus.req[IDX_W'(i)]) fix_win = IDX_W'(i);
        end
        for (int k = int'(N_SRC); k >= 1; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(N_SRC)) idx = idx - int'(N_SRC);
            if (bus.req[IDX_W'(idx)]) rr_win = IDX_W'(idx);
        end
    end

    // Next state, owner, pointer and registered-output values.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        arb     = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) arb = 1'b1;
            end
            OWN: begin
                if (bus.hold && bus.req[owner_q]) begin
                    state_d = OWN;
                end else if (any_req) begin
                    arb = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh decision always moves the round-robin pointer to the winner.
        if (arb) begin
            owner_d = bus.rr_mode ? rr_win : fix_win;
            ptr_d   = owner_d;
            state_d = OWN;
        end

        sel_d   = (state_d == OWN) ? SEL_W'(owner_d) + SEL_W'(1) : '0;
        grant_d = (state_d == OWN) ? (N_SRC'(1) << owner_d) : '0;
        valid_d = (state_d == OWN);

        // Counter counts cycles in which the conflict flag is shown; clear wins.
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (conflict_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= IDX_W'(N_SRC - 1);
            sel_q      <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_now;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.sel          = sel_q;
    assign bus.grant        = grant_q;
    assign bus.bus_valid    = valid_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_bus_src_arbiter.sv
// Bench for bus_src_arbiter: directed scenarios plus random traffic against a
// behavioural model. A second instance with a 2-bit counter sees the same inputs.
module tb_bus_src_arbiter;
    localparam int N = 7;

    logic clk;
    logic rst_n;

    bus_src_arbiter_if #(.N_SRC(7), .SEL_W(3), .CNT_W(8)) b0 ();
    bus_src_arbiter_if #(.N_SRC(7), .SEL_W(3), .CNT_W(2)) b1 ();

    bus_src_arbiter #(.N_SRC(7), .SEL_W(3), .CNT_W(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );

    bus_src_arbiter #(.N_SRC(7), .SEL_W(3), .CNT_W(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: current owner (-1 = none), last granted index, conflict flag, counters.
    int m_owner;
    int m_ptr;
    bit m_conf;
    int m_cnt0;
    int m_cnt1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_conf  = 1'b0;
        m_cnt0  = 0;
        m_cnt1  = 0;
    endtask

    task automatic model_step(input logic [6:0] r, input bit rr, input bit h, input bit clr);
        int pc;
        int w;
        pc = 0;
        for (int i = 0; i < N; i++) pc += int'(r[i]);
        if (clr) begin
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else if (m_conf) begin
            if (m_cnt0 < 255) m_cnt0++;
            if (m_cnt1 < 3) m_cnt1++;
        end
        m_conf = (pc >= 2);
        if (m_owner >= 0 && h && r[m_owner]) begin
            // owner keeps the bus; pointer untouched
        end else if (r == 7'd0) begin
            m_owner = -1;
        end else begin
            w = -1;
            if (!rr) begin
                for (int i = N - 1; i >= 0; i--) if (r[i]) w = i;
            end else begin
                for (int k = 1; k <= N && w < 0; k++) begin
                    if (r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
            end
            m_owner = w;
            m_ptr   = w;
        end
    endtask

    task automatic set_in(input logic [6:0] r, input bit rr, input bit h, input bit clr);
        b0.req = r;  b0.rr_mode = rr;  b0.hold = h;  b0.clr_cnt = clr;
        b1.req = r;  b1.rr_mode = rr;  b1.hold = h;  b1.clr_cnt = clr;
    endtask

    task automatic check_model(input string tag);
        int exp_sel;
        int exp_grant;
        exp_sel   = (m_owner < 0) ? 0 : m_owner + 1;
        exp_grant = (m_owner < 0) ? 0 : (1 << m_owner);
        chk({tag, "/sel"},   32'(b0.sel),          32'(exp_sel));
        chk({tag, "/grant"}, 32'(b0.grant),        32'(exp_grant));
        chk({tag, "/valid"}, 32'(b0.bus_valid),    32'(m_owner >= 0));
        chk({tag, "/conf"},  32'(b0.conflict),     32'(m_conf));
        chk({tag, "/cnt8"},  32'(b0.conflict_cnt), 32'(m_cnt0));
        chk({tag, "/cnt2"},  32'(b1.conflict_cnt), 32'(m_cnt1));
        chk({tag, "/sel2"},  32'(b1.sel),          32'(exp_sel));
    endtask

    // One clock: inputs already driven, advance model at the edge, sample 1ns later.
    task automatic tick(input string tag);
        logic [6:0] r;
        bit rr, h, clr;
        r = b0.req;  rr = b0.rr_mode;  h = b0.hold;  clr = b0.clr_cnt;
        @(posedge clk);
        model_step(r, rr, h, clr);
        #1;
        check_model(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/sel"},   32'(b0.sel),          0);
        chk({tag, "/grant"}, 32'(b0.grant),        0);
        chk({tag, "/valid"}, 32'(b0.bus_valid),    0);
        chk({tag, "/conf"},  32'(b0.conflict),     0);
        chk({tag, "/cnt"},   32'(b0.conflict_cnt), 0);
        chk({tag, "/cnt2"},  32'(b1.conflict_cnt), 0);
    endtask

    initial begin
        logic [6:0] r;
        bit rr, h, clr;

        // Reset and fixed priority
        rst_n = 1'b0;
        set_in(7'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        set_in(7'b1000110, 1'b0, 1'b0, 1'b0);
        tick("fp1");
        chk("fp_sel",   32'(b0.sel), 2);
        chk("fp_grant", 32'(b0.grant), 32'h02);
        chk("fp_valid", 32'(b0.bus_valid), 1);
        chk("fp_conf",  32'(b0.conflict), 1);
        tick("fp2");
        chk("fp_cnt", 32'(b0.conflict_cnt), 1);

        // Round-robin rotation from a fresh pointer
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        set_in(7'h7f, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick("rr");
            chk("rr_sel", 32'(b0.sel), 32'((i % 7) + 1));
            if (i >= 4) chk("sat_cnt2", 32'(b1.conflict_cnt), 3);
        end

        // Idle and release
        set_in(7'd0, 1'b1, 1'b0, 1'b0);
        tick("idle");
        chk("idle_sel",   32'(b0.sel), 0);
        chk("idle_grant", 32'(b0.grant), 0);
        chk("idle_valid", 32'(b0.bus_valid), 0);
        chk("idle_conf",  32'(b0.conflict), 0);
        chk("rr_cnt8",    32'(b0.conflict_cnt), 8);
        chk("sat_hold",   32'(b1.conflict_cnt), 3);

        // Clear beats increment
        set_in(7'b0000011, 1'b0, 1'b0, 1'b0);
        tick("pre_clr");
        set_in(7'b0000011, 1'b0, 1'b0, 1'b1);
        tick("clr");
        chk("clr_cnt8", 32'(b0.conflict_cnt), 0);
        chk("clr_cnt2", 32'(b1.conflict_cnt), 0);

        // Hold keeps Memory, release hands over the same cycle
        set_in(7'b1000000, 1'b0, 1'b1, 1'b0);
        tick("hold0");
        chk("hold_own", 32'(b0.sel), 7);
        set_in(7'b1000001, 1'b0, 1'b1, 1'b0);
        tick("hold1");
        chk("hold_keep1", 32'(b0.sel), 7);
        tick("hold2");
        chk("hold_keep2", 32'(b0.sel), 7);
        set_in(7'b0000001, 1'b0, 1'b1, 1'b0);
        tick("hold3");
        chk("hold_rel", 32'(b0.sel), 1);

        // Asynchronous reset between edges
        set_in(7'b0001000, 1'b0, 1'b0, 1'b0);
        tick("pre_arst");
        chk("arst_pre_sel", 32'(b0.sel), 4);
        #2 rst_n = 1'b0;
        #1;
        check_zero("arst");
        model_reset();
        set_in(7'b0100000, 1'b1, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        tick("post_arst");
        chk("arst_sel", 32'(b0.sel), 6);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            r   = 7'($urandom);
            if ($urandom_range(3) == 0) r = 7'd0;
            if ($urandom_range(3) == 0) r = r & 7'($urandom);
            rr  = bit'($urandom_range(1));
            h   = ($urandom_range(2) != 0);
            clr = ($urandom_range(15) == 0);
            set_in(r, rr, h, clr);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_src_arbiter.md
# bus_src_arbiter

Parametrised, registered common-bus source selector for the basic-computer datapath. It replaces the purely combinational fixed-priority 8-to-3 bus encoder. It accepts N_SRC per-source bus requests and drives a binary bus-select code plus a one-hot grant. It supports fixed-priority or round-robin arbitration, ownership hold across multi-cycle transfers, and a saturating count of cycles with request conflicts.

## Interface
- N_SRC, default 7: number of bus sources (>=2). Request bit i maps to select code i+1; code 0 means no source.
- SEL_W, default 3: select-code width; must satisfy 2**SEL_W >= N_SRC+1.
- CNT_W, default 8: conflict-counter width.
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_SRC  per-source bus request; bit 0 = AR, 1 = PC, 2 = DR, 3 = AC, 4 = IR, 5 = TR, 6 = Memory in default configuration.
- rr_mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- hold  input  1  current owner keeps the bus while its request stays high.
- clr_cnt  input  1  synchronous clear of conflict_cnt.
- sel  output  SEL_W  registered bus-select code (0 or owner index+1).
- grant  output  N_SRC  registered one-hot grant, consistent with sel (all-zero when sel=0).
- bus_valid  output  1  registered; 1 when sel != 0.
- conflict  output  1  registered one-cycle pulse: two or more req bits were high in the previous cycle.
- conflict_cnt  output  CNT_W  saturating count of conflict cycles.

## Operation
- Two states: IDLE (no owner) and OWN (owner index o).
- IDLE: if any req bit is high, select the winner and go to OWN. Otherwise stay in IDLE with sel=0.
- OWN, no hold: re-arbitrate every cycle among current req bits. If none are high, go to IDLE.
- OWN, hold=1 and req[o]=1: keep o regardless of other requests; the round-robin pointer is unchanged.
- OWN, hold=1 and req[o]=0: release. Re-arbitrate among remaining requests the same cycle, or go to IDLE.
- Fixed priority: lowest set index wins, matching the prior encoder order (AR highest, Memory lowest).
- Round-robin: pointer p holds the last granted index. The search starts at p+1 and wraps from N_SRC-1 to 0; the first set bit wins. p updates only on a new grant, including a re-grant to the same index after a search.
- rr_mode may change at any time; it is sampled at each arbitration decision and has no effect during a hold.
- Conflict: popcount(req) >= 2 in cycle k sets conflict=1 in cycle k+1, otherwise 0. This applies independent of state and hold.
- conflict_cnt increments on each conflict cycle and saturates at 2**CNT_W-1 with no wrap.
- clr_cnt has priority over increment: clear and conflict in the same cycle yields 0.
- Request bits at positions >= N_SRC do not exist; code values above N_SRC are never driven.

## Timing
- Latency: req sampled at edge k drives sel, grant and bus_valid after edge k, i.e. valid throughout cycle k+1. Outputs are registered with no combinational path from input to output.
- Hold is sampled at the same edge as req.
- Reset (rst_n low, asynchronous): sel=0, grant=0, bus_valid=0, conflict=0, conflict_cnt=0, p=N_SRC-1 (first round-robin search starts at index 0), state=IDLE.
- Reset released mid-transfer: the block restarts in IDLE; the first grant follows one cycle after requests are sampled.
- Reset deassertion is synchronised externally; the block requires no special handling.

## Test plan
- Reset and priority (N_SRC=7, rr_mode=0): assert rst_n=0 and check all outputs are 0. Release reset, then drive req=7'b1000110. The next cycle must show sel=2, grant=7'b0000010, bus_valid=1, conflict=1, and conflict_cnt=1 one cycle later.
- Round-robin rotation: rr_mode=1 with req=7'b1111111 held for 8 cycles. sel must step 1,2,3,4,5,6,7,1, and conflict_cnt must reach 8.
- Hold: owner sel=7 (Memory) with hold=1, then raise req[0]. sel must stay 7. Drop req[6] with hold=1; the next cycle must show sel=1.
- Idle and release: drop all req from an owned state. The next cycle must show sel=0, grant=0, bus_valid=0, conflict=0.
- Counter saturation and clear: CNT_W=2 with 5 conflict cycles. conflict_cnt must read 3 and stay at 3. Assert clr_cnt alongside a conflict; the next cycle must show conflict_cnt=0.
- Asynchronous reset mid-operation: pull rst_n low between edges while sel=4. Outputs must drop to 0 immediately, without waiting for clk. After release with req=7'b0100000 and rr_mode=1, sel must be 6.
